wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Round-robin arbiter that shares one register-file write port between two pipeline requesters: port 0 is the ALU/EX result and port 1 is the load/MEM return. It sequences multi-beat bursts and drives the select line of the 2:1 write-data/write-address mux bank feeding the register file. Grants are registered so the mux select is glitch-free and stable for each whole burst.

Parameters:
LEN_W, 2, width of burst-length fields; burst beats = len+1 (1..2^LEN_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
req0  input  1  port 0 request; held high for the whole burst
len0  input  LEN_W  port 0 burst length minus one; sampled only when the grant is issued
req1  input  1  port 1 request; held high for the whole burst
len1  input  LEN_W  port 1 burst length minus one; sampled only when the grant is issued
gnt0  output  1  port 0 owns the write port this cycle (one beat per high cycle)
gnt1  output  1  port 1 owns the write port this cycle
sel  output  1  mux select: 0 = port 0, 1 = port 1
busy  output  1  gnt0|gnt1; write-enable qualifier for the register file
beat_last  output  1  current beat is the final beat of the burst

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, gnt0=0, gnt1=0, sel=0, busy=0, beat_last=0, cnt=0, last_winner=1 (port 0 wins the first tie).
- All outputs are registered. gnt0 and gnt1 are never high together.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - No request: stay in IDLE; sel holds its previous value.
  - Exactly one reqX high: next state GNTX.
  - Both high: grant the port that is not last_winner.
  - Latency: a request sampled at edge N gives gntX=1 in the cycle after edge N.
- Entering GNTX:
  - cnt <= lenX; sel <= X; gntX <= 1; last_winner <= X.
  - beat_last <= (lenX==0).
- In GNTX, each cycle is one beat:
  - If cnt!=0: cnt decrements.
  - beat_last = (cnt==0).
- End of burst (cnt==0 at the edge), re-arbitration on the same edge with no idle bubble:
  - Other port requesting: switch to the other GNT state.
  - Else reqX still high: regrant X with a new lenX (back-to-back burst).
  - Else: IDLE, with gnt low next cycle.
- Abort: reqX sampled low while in GNTX with cnt!=0:
  - Treated as end of burst: gntX drops next cycle and re-arbitration follows the rules above.
  - last_winner stays X.
- A request arriving mid-burst on the other port waits; it is never starved, because the other port is always preferred at the next end-of-burst.
- len changes while granted are ignored.
- Reset assertion mid-burst: all outputs go to reset values immediately (asynchronously). After release, arbitration restarts from IDLE with last_winner=1.
- cnt arithmetic is unsigned LEN_W bits; no wrap, because a decrement occurs only when cnt!=0.

Test Plan:
- Reset/idle: hold rst_n=0, then release with no requests -> gnt0=gnt1=0, sel=0, busy=0 for 10 cycles.
- Single burst: req0=1, len0=2 for 3 cycles -> gnt0 high exactly 3 cycles starting 1 cycle after req; beat_last only on the 3rd; sel=0; then IDLE.
- Tie plus round robin: req0=req1=1 together, len0=len1=1, held -> grants GNT0 x2, GNT1 x2, GNT0 x2, alternating with no bubble cycles; never both grants high.
- Back-to-back same port: req1 held, len1=0 -> gnt1 continuously high; beat_last=1 every cycle; sel=1 stable.
- Abort: req0 with len0=3 dropped after 2 beats while req1=1 -> gnt0 falls after beat 2 (plus 1-cycle sampling); gnt1 rises the same cycle gnt0 falls; sel=1.
- Async reset mid-burst: pull rst_n low during GNT1 with cnt=2, off the clock edge -> gnt1, busy, sel go to 0 immediately; after release with both requesting, port 0 is granted first.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester/arbiter bundle for the register-file write port
interface wb_port_arbiter_if #(
  parameter int LEN_W = 2
);
  logic             req0;
  logic [LEN_W-1:0] len0;
  logic             req1;
  logic [LEN_W-1:0] len1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic             busy;
  logic             beat_last;

  // Requester side: drives requests and burst lengths, observes grants.
  modport master (
    output req0, len0, req1, len1,
    input  gnt0, gnt1, sel, busy, beat_last
  );

  // Arbiter side.
  modport slave (
    input  req0, len0, req1, len1,
    output gnt0, gnt1, sel, busy, beat_last
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin burst arbiter for the register-file write port
module wb_port_arbiter #(
  parameter int LEN_W = 2
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] cntZero = '0;
  localparam logic [LEN_W-1:0] cntOne  = LEN_W'(1);

  state_t           state, nextState;
  logic [LEN_W-1:0] cnt, nextCnt;
  logic             lastWinner, nextLastWinner;
  logic             selQ, nextSel;
  logic             beatLastQ, nextBeatLast;
  logic             gnt0Q, gnt1Q, busyQ;
  logic             arbitrate;
  logic             pick0, pick1;

  // Next-state, counter and registered-output decode; every grant decision
  // (from IDLE or at end of burst/abort) goes through the same arbitration.
  always_comb begin
    nextState      = state;
    nextCnt        = cnt;
    nextLastWinner = lastWinner;
    nextSel        = selQ;
    nextBeatLast   = 1'b0;
    arbitrate      = 1'b0;
    pick0          = 1'b0;
    pick1          = 1'b0;

    case (state)
      IDLE: arbitrate = 1'b1;
      GNT0: begin
        if (cnt != cntZero && bus.req0) begin
          nextCnt      = cnt - cntOne;
          nextBeatLast = (cnt == cntOne);
        end else begin
          arbitrate = 1'b1;
        end
      end
      GNT1: begin
        if (cnt != cntZero && bus.req1) begin
          nextCnt      = cnt - cntOne;
          nextBeatLast = (cnt == cntOne);
        end else begin
          arbitrate = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase

    if (arbitrate) begin
      // On a tie the port that did not win last time is chosen; at end of a
      // burst lastWinner is the current owner, so the other port is preferred.
      pick0 = bus.req0 && (!bus.req1 || lastWinner);
      pick1 = bus.req1 && (!bus.req0 || !lastWinner);
      if (pick0) begin
        nextState      = GNT0;
        nextCnt        = bus.len0;
        nextSel        = 1'b0;
        nextLastWinner = 1'b0;
        nextBeatLast   = (bus.len0 == cntZero);
      end else if (pick1) begin
        nextState      = GNT1;
        nextCnt        = bus.len1;
        nextSel        = 1'b1;
        nextLastWinner = 1'b1;
        nextBeatLast   = (bus.len1 == cntZero);
      end else begin
        nextState    = IDLE;
        nextCnt      = cntZero;
        nextBeatLast = 1'b0;
      end
    end
  end

  // State and output registers; grants come straight from flops so the mux
  // select never glitches within a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= cntZero;
      lastWinner <= 1'b1;
      selQ       <= 1'b0;
      beatLastQ  <= 1'b0;
      gnt0Q      <= 1'b0;
      gnt1Q      <= 1'b0;
      busyQ      <= 1'b0;
    end else begin
      state      <= nextState;
      cnt        <= nextCnt;
      lastWinner <= nextLastWinner;
      selQ       <= nextSel;
      beatLastQ  <= nextBeatLast;
      gnt0Q      <= (nextState == GNT0);
      gnt1Q      <= (nextState == GNT1);
      busyQ      <= (nextState == GNT0) || (nextState == GNT1);
    end
  end

  assign bus.gnt0      = gnt0Q;
  assign bus.gnt1      = gnt1Q;
  assign bus.sel       = selQ;
  assign bus.busy      = busyQ;
  assign bus.beat_last = beatLastQ;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int LEN_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.LEN_W(LEN_W)) bus ();

  wb_port_arbiter #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [4:0] expQ[$];
  string      tagQ[$];
  int         vectors     = 0;
  int         miscompares = 0;

  // Expected output vector: {gnt0, gnt1, sel, busy, beat_last}.
  function automatic logic [4:0] mkExp(input logic g0, input logic g1,
                                       input logic s, input logic bl);
    return {g0, g1, s, g0 | g1, bl};
  endfunction

  task automatic check(input string tag, input logic [4:0] expVal);
    logic [4:0] obs;
    obs = {bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.beat_last};
    vectors++;
    assert (obs === expVal) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b (gnt0 gnt1 sel busy last)", tag, obs, expVal);
    end
  endtask

  // Drive one cycle of requests at the falling edge, queue the outputs
  // expected after the next rising edge, then compare just after it.
  task automatic step(input string tag,
                      input logic r0, input logic [LEN_W-1:0] l0,
                      input logic r1, input logic [LEN_W-1:0] l1,
                      input logic g0, input logic g1, input logic s, input logic bl);
    @(negedge clk);
    bus.req0 = r0;
    bus.len0 = l0;
    bus.req1 = r1;
    bus.len1 = l1;
    expQ.push_back(mkExp(g0, g1, s, bl));
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    check(tagQ.pop_front(), expQ.pop_front());
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.len0 = '0;
    bus.req1 = 1'b0;
    bus.len1 = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("reset", mkExp(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Single 3-beat burst on port 0; len changes mid-burst are ignored
    step("single_b1", 1, 2, 0, 0, 1, 0, 0, 0);
    step("single_b2", 1, 0, 0, 0, 1, 0, 0, 0);
    step("single_b3", 1, 0, 0, 0, 1, 0, 0, 1);
    step("single_end", 0, 0, 0, 0, 0, 0, 0, 0);
    step("single_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back single-beat bursts on port 1, then sel holds in IDLE
    for (int i = 0; i < 5; i++) step("b2b_port1", 0, 0, 1, 0, 0, 1, 1, 1);
    step("b2b_end", 0, 0, 0, 0, 0, 0, 1, 0);
    step("idle_sel_hold", 0, 0, 0, 0, 0, 0, 1, 0);

    // Tie with 2-beat bursts: port 0 first, then strict alternation
    for (int i = 0; i < 2; i++) begin
      step("rr_p0_b1", 1, 1, 1, 1, 1, 0, 0, 0);
      step("rr_p0_b2", 1, 1, 1, 1, 1, 0, 0, 1);
      step("rr_p1_b1", 1, 1, 1, 1, 0, 1, 1, 0);
      step("rr_p1_b2", 1, 1, 1, 1, 0, 1, 1, 1);
    end
    step("rr_end", 0, 0, 0, 0, 0, 0, 1, 0);

    // Abort: port 0 drops its 4-beat request after 2 beats, port 1 takes over
    step("abort_b1", 1, 3, 1, 0, 1, 0, 0, 0);
    step("abort_b2", 1, 3, 1, 0, 1, 0, 0, 0);
    step("abort_switch", 0, 3, 1, 0, 0, 1, 1, 1);
    step("abort_end", 0, 0, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a port 1 burst with cnt=2
    step("arst_b1", 0, 0, 1, 3, 0, 1, 1, 0);
    step("arst_b2", 0, 0, 1, 3, 0, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", mkExp(0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_hold", mkExp(0, 0, 0, 0));
    @(negedge clk);
    bus.req1 = 1'b0;
    rst_n = 1'b1;
    step("post_rst_p0_b1", 1, 1, 1, 0, 1, 0, 0, 0);
    step("post_rst_p0_b2", 1, 1, 1, 0, 1, 0, 0, 1);
    step("post_rst_p1", 0, 0, 1, 0, 0, 1, 1, 1);
    step("post_rst_end", 0, 0, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
